// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter in front of the CPU memory block.
// Port 0 is the load/store unit, port 1 instruction fetch; one transaction in flight.
module wb_arbiter2 #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_stb,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic        i_m0_we,
    input  logic [2:0]  i_m0_sel,
    output logic [31:0] o_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_stall,
    input  logic        i_m1_stb,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic        i_m1_we,
    input  logic [2:0]  i_m1_sel,
    output logic [31:0] o_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_stall,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_wb_we,
    output logic [2:0]  o_wb_sel,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT0, WAIT1} state_t;

    state_t             state, state_nx;
    logic               last_grant;
    logic [31:0]        lat_addr, lat_data;
    logic               lat_we;
    logic [2:0]         lat_sel;
    logic [CNT_W-1:0]   wait_cnt;
    logic               req_any, grant_port, timed_out;

    // On a tie, round-robin favours the port that did not win last time
    always_comb begin
        req_any    = i_m0_stb | i_m1_stb;
        grant_port = i_m1_stb;
        if (i_m0_stb && i_m1_stb)
            grant_port = ROUND_ROBIN ? ~last_grant : 1'b0;
    end

    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_W'(CNT_LAST));

    assign o_wb_addr = lat_addr;
    assign o_wb_data = lat_data;
    assign o_wb_we   = lat_we;
    assign o_wb_sel  = lat_sel;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_we     <= 1'b0;
            lat_sel    <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_any) begin
                last_grant <= grant_port;
                if (grant_port) begin
                    lat_addr <= i_m1_addr;
                    lat_data <= i_m1_data;
                    lat_we   <= i_m1_we;
                    lat_sel  <= i_m1_sel;
                end else begin
                    lat_addr <= i_m0_addr;
                    lat_data <= i_m0_data;
                    lat_we   <= i_m0_we;
                    lat_sel  <= i_m0_sel;
                end
            end
            // Held at zero while issuing so every wait starts from a clean count
            if (state == ISSUE0 || state == ISSUE1)
                wait_cnt <= '0;
            else if (state == WAIT0 || state == WAIT1)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx   = state;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m1_err   = 1'b0;
        o_m0_data  = '0;
        o_m1_data  = '0;
        o_wb_stb   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (grant_port) begin
                        o_m1_stall = 1'b0;
                        state_nx   = ISSUE1;
                    end else begin
                        o_m0_stall = 1'b0;
                        state_nx   = ISSUE0;
                    end
                end
            end
            ISSUE0: begin
                o_wb_stb = 1'b1;
                if (!i_wb_stall) state_nx = WAIT0;
            end
            ISSUE1: begin
                o_wb_stb = 1'b1;
                if (!i_wb_stall) state_nx = WAIT1;
            end
            WAIT0: begin
                if (i_wb_ack) begin
                    o_m0_ack  = 1'b1;
                    o_m0_data = i_wb_data;
                    state_nx  = IDLE;
                end else if (timed_out) begin
                    o_m0_ack = 1'b1;
                    o_m0_err = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT1: begin
                if (i_wb_ack) begin
                    o_m1_ack  = 1'b1;
                    o_m1_data = i_wb_data;
                    state_nx  = IDLE;
                end else if (timed_out) begin
                    o_m1_ack = 1'b1;
                    o_m1_err = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a round-robin/timeout instance driven from a vector
// table and corner sequences, plus a fixed-priority instance under constant contention.
module tb_wb_arbiter2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_stb, m1_stb, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [2:0]  m0_sel, m1_sel;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic        wb_stb, wb_we, wb_ack, wb_stall;
    logic [31:0] wb_addr, wb_wdata, wb_rdata;
    logic [2:0]  wb_sel;

    logic        mem_rst, mem_ack_en;
    logic [1:0]  pipe;

    logic        f_stb0, f_stb1;
    logic [31:0] f_rdata0, f_rdata1, f_wb_addr, f_wb_wdata;
    logic        f_ack0, f_err0, f_stall0, f_ack1, f_err1, f_stall1;
    logic        f_wb_stb, f_wb_we, f_wb_ack;
    logic [2:0]  f_wb_sel;
    logic [1:0]  f_pipe;

    int n_chk  = 0;
    int n_fail = 0;

    wb_arbiter2 #(.ROUND_ROBIN(1'b1), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_stb(m0_stb), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata), .i_m0_we(m0_we), .i_m0_sel(m0_sel),
        .o_m0_data(m0_rdata), .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_stall(m0_stall),
        .i_m1_stb(m1_stb), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata), .i_m1_we(m1_we), .i_m1_sel(m1_sel),
        .o_m1_data(m1_rdata), .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_stall(m1_stall),
        .o_wb_stb(wb_stb), .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
        .i_wb_data(wb_rdata), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall)
    );

    wb_arbiter2 #(.ROUND_ROBIN(1'b0), .TIMEOUT(0)) dut_fp (
        .i_clk(clk), .i_reset(rst),
        .i_m0_stb(f_stb0), .i_m0_addr(32'h10), .i_m0_data(32'h0), .i_m0_we(1'b0), .i_m0_sel(3'b010),
        .o_m0_data(f_rdata0), .o_m0_ack(f_ack0), .o_m0_err(f_err0), .o_m0_stall(f_stall0),
        .i_m1_stb(f_stb1), .i_m1_addr(32'h20), .i_m1_data(32'h0), .i_m1_we(1'b0), .i_m1_sel(3'b010),
        .o_m1_data(f_rdata1), .o_m1_ack(f_ack1), .o_m1_err(f_err1), .o_m1_stall(f_stall1),
        .o_wb_stb(f_wb_stb), .o_wb_addr(f_wb_addr), .o_wb_data(f_wb_wdata), .o_wb_we(f_wb_we), .o_wb_sel(f_wb_sel),
        .i_wb_data(32'h600D_0000), .i_wb_ack(f_wb_ack), .i_wb_stall(1'b0)
    );

    // Memory models: acknowledge two cycles after accepting a strobe
    always @(posedge clk) begin
        if (mem_rst) begin
            pipe   <= 2'b00;
            f_pipe <= 2'b00;
        end else begin
            pipe   <= {pipe[0], wb_stb & ~wb_stall};
            f_pipe <= {f_pipe[0], f_wb_stb};
        end
    end
    assign wb_ack   = pipe[1] & mem_ack_en;
    assign f_wb_ack = f_pipe[1];

    typedef struct {
        logic        s0, s1;
        logic [31:0] a1, d1;
        logic        we1;
        logic [2:0]  sel1;
        logic [31:0] mem;
        logic        e_st0, e_st1, e_wb;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wd;
        logic [2:0]  e_sel;
        logic        e_ack0;
        logic [31:0] e_d0;
        logic        e_ack1;
        logic [31:0] e_d1;
    } vec_t;

    function automatic vec_t mk(logic s0, logic s1, logic [31:0] a1, logic [31:0] d1, logic we1,
                                logic [2:0] sel1, logic [31:0] mem, logic est0, logic est1, logic ewb,
                                logic [31:0] eaddr, logic ewe, logic [31:0] ewd, logic [2:0] esel,
                                logic eack0, logic [31:0] ed0, logic eack1, logic [31:0] ed1);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.a1 = a1; v.d1 = d1; v.we1 = we1; v.sel1 = sel1; v.mem = mem;
        v.e_st0 = est0; v.e_st1 = est1; v.e_wb = ewb; v.e_addr = eaddr; v.e_we = ewe;
        v.e_wd = ewd; v.e_sel = esel; v.e_ack0 = eack0; v.e_d0 = ed0; v.e_ack1 = eack1; v.e_d1 = ed1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vec[18];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: s0 s1 a1 d1 we1 sel1 mem | stall0 stall1 wb_stb addr we wdata sel | ack0 d0 ack1 d1
        vec[0]  = mk(0,1'b0,32'h20,0,0,3'b010,0,            1,1,0,0,0,0,0,               0,0,0,0);
        vec[1]  = mk(1,1,32'h20,0,0,3'b010,0,               0,1,0,0,0,0,0,               0,0,0,0);
        vec[2]  = mk(0,1,32'h20,0,0,3'b010,0,               1,1,1,32'h10,0,0,3'b010,     0,0,0,0);
        vec[3]  = mk(0,1,32'h20,0,0,3'b010,0,               1,1,0,0,0,0,0,               0,0,0,0);
        vec[4]  = mk(0,1,32'h20,0,0,3'b010,32'hDEADBEEF,    1,1,0,0,0,0,0,               1,32'hDEADBEEF,0,0);
        vec[5]  = mk(1,1,32'h20,0,0,3'b010,0,               1,0,0,0,0,0,0,               0,0,0,0);
        vec[6]  = mk(1,0,32'h20,0,0,3'b010,0,               1,1,1,32'h20,0,0,3'b010,     0,0,0,0);
        vec[7]  = mk(1,0,32'h20,0,0,3'b010,0,               1,1,0,0,0,0,0,               0,0,0,0);
        vec[8]  = mk(1,0,32'h20,0,0,3'b010,32'h12345678,    1,1,0,0,0,0,0,               0,0,1,32'h12345678);
        vec[9]  = mk(1,1,32'h20,0,0,3'b010,0,               0,1,0,0,0,0,0,               0,0,0,0);
        vec[10] = mk(0,1,32'h20,0,0,3'b010,0,               1,1,1,32'h10,0,0,3'b010,     0,0,0,0);
        vec[11] = mk(0,1,32'h20,0,0,3'b010,0,               1,1,0,0,0,0,0,               0,0,0,0);
        vec[12] = mk(0,1,32'h20,0,0,3'b010,32'hCAFEF00D,    1,1,0,0,0,0,0,               1,32'hCAFEF00D,0,0);
        vec[13] = mk(1,1,32'h3,32'hAB,1,3'b000,0,           1,0,0,0,0,0,0,               0,0,0,0);
        vec[14] = mk(1,0,32'h3,32'hAB,1,3'b000,0,           1,1,1,32'h3,1,32'hAB,3'b000, 0,0,0,0);
        vec[15] = mk(0,0,32'h3,32'hAB,1,3'b000,0,           1,1,0,0,0,0,0,               0,0,0,0);
        vec[16] = mk(0,0,32'h3,32'hAB,1,3'b000,32'h77,      1,1,0,0,0,0,0,               0,0,1,32'h77);
        vec[17] = mk(0,0,32'h20,0,0,3'b010,32'h5555,        1,1,0,0,0,0,0,               0,0,0,0);

        rst = 1'b1; mem_rst = 1'b1; mem_ack_en = 1'b1; wb_stall = 1'b0; wb_rdata = '0;
        m0_stb = 1'b0; m0_addr = 32'h10; m0_wdata = '0; m0_we = 1'b0; m0_sel = 3'b010;
        m1_stb = 1'b0; m1_addr = 32'h20; m1_wdata = '0; m1_we = 1'b0; m1_sel = 3'b010;
        f_stb0 = 1'b0; f_stb1 = 1'b0;
        next_cycle();
        next_cycle();
        chk("reset wb_stb", 32'(wb_stb), 0);
        chk("reset ack0", 32'(m0_ack), 0);
        chk("reset ack1", 32'(m1_ack), 0);
        chk("reset stall0", 32'(m0_stall), 1);
        chk("reset wb_addr", wb_addr, 0);
        rst = 1'b0; mem_rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            next_cycle();
            m0_stb = vec[i].s0; m1_stb = vec[i].s1;
            m1_addr = vec[i].a1; m1_wdata = vec[i].d1; m1_we = vec[i].we1; m1_sel = vec[i].sel1;
            wb_rdata = vec[i].mem;
            #1;
            chk($sformatf("r%0d stall0", i), 32'(m0_stall), 32'(vec[i].e_st0));
            chk($sformatf("r%0d stall1", i), 32'(m1_stall), 32'(vec[i].e_st1));
            chk($sformatf("r%0d wb_stb", i), 32'(wb_stb), 32'(vec[i].e_wb));
            chk($sformatf("r%0d ack0", i), 32'(m0_ack), 32'(vec[i].e_ack0));
            chk($sformatf("r%0d ack1", i), 32'(m1_ack), 32'(vec[i].e_ack1));
            chk($sformatf("r%0d data0", i), m0_rdata, vec[i].e_d0);
            chk($sformatf("r%0d data1", i), m1_rdata, vec[i].e_d1);
            chk($sformatf("r%0d err0", i), 32'(m0_err), 0);
            chk($sformatf("r%0d err1", i), 32'(m1_err), 0);
            if (vec[i].e_wb) begin
                chk($sformatf("r%0d wb_addr", i), wb_addr, vec[i].e_addr);
                chk($sformatf("r%0d wb_we", i), 32'(wb_we), 32'(vec[i].e_we));
                chk($sformatf("r%0d wb_data", i), wb_wdata, vec[i].e_wd);
                chk($sformatf("r%0d wb_sel", i), 32'(wb_sel), 32'(vec[i].e_sel));
            end
        end
        m1_addr = 32'h20; m1_wdata = '0; m1_we = 1'b0; m1_sel = 3'b010;

        // Memory stall holds the issue phase for two cycles
        next_cycle(); m0_stb = 1'b1; m0_addr = 32'h40; wb_stall = 1'b1; #1;
        chk("stall accept", 32'(m0_stall), 0);
        next_cycle(); m0_stb = 1'b0; #1;
        chk("stall issue1 stb", 32'(wb_stb), 1);
        chk("stall issue1 addr", wb_addr, 32'h40);
        next_cycle(); wb_stall = 1'b0; #1;
        chk("stall issue2 stb", 32'(wb_stb), 1);
        next_cycle(); #1;
        chk("stall wait stb", 32'(wb_stb), 0);
        chk("stall wait ack0", 32'(m0_ack), 0);
        next_cycle(); wb_rdata = 32'h0BADF00D; #1;
        chk("stall ack0", 32'(m0_ack), 1);
        chk("stall data0", m0_rdata, 32'h0BADF00D);

        // Silent memory: forced error completion on the 8th wait cycle
        next_cycle(); mem_ack_en = 1'b0; wb_rdata = 32'hFFFFFFFF; m0_stb = 1'b1; m0_addr = 32'h10; #1;
        chk("to accept", 32'(m0_stall), 0);
        next_cycle(); m0_stb = 1'b0; #1;
        chk("to issue", 32'(wb_stb), 1);
        for (int k = 1; k <= 7; k++) begin
            next_cycle(); #1;
            chk($sformatf("to wait%0d ack0", k), 32'(m0_ack), 0);
            chk($sformatf("to wait%0d err0", k), 32'(m0_err), 0);
        end
        next_cycle(); #1;
        chk("to wait8 ack0", 32'(m0_ack), 1);
        chk("to wait8 err0", 32'(m0_err), 1);
        chk("to wait8 data0", m0_rdata, 0);
        chk("to wait8 ack1", 32'(m1_ack), 0);
        next_cycle(); m1_stb = 1'b1; #1;
        chk("to idle ack0", 32'(m0_ack), 0);
        chk("to idle err0", 32'(m0_err), 0);
        chk("to idle grant1", 32'(m1_stall), 0);
        next_cycle(); m1_stb = 1'b0; mem_ack_en = 1'b1; wb_rdata = '0; #1;
        chk("to m1 issue", 32'(wb_stb), 1);
        next_cycle(); #1;
        next_cycle(); wb_rdata = 32'h1; #1;
        chk("to m1 ack", 32'(m1_ack), 1);
        chk("to m1 err", 32'(m1_err), 0);
        chk("to m1 data", m1_rdata, 32'h1);

        // Reset while waiting abandons the transaction and restores tie priority
        next_cycle(); m0_stb = 1'b1; wb_rdata = 32'h99; #1;
        chk("rw accept", 32'(m0_stall), 0);
        next_cycle(); m0_stb = 1'b0; #1;
        next_cycle(); #1;
        chk("rw wait stb", 32'(wb_stb), 0);
        rst = 1'b1;
        next_cycle(); rst = 1'b0; #1;
        chk("rw late ack0", 32'(m0_ack), 0);
        chk("rw late data0", m0_rdata, 0);
        chk("rw wb_stb", 32'(wb_stb), 0);
        chk("rw idle stall0", 32'(m0_stall), 1);
        next_cycle(); m0_stb = 1'b1; m1_stb = 1'b1; #1;
        chk("rw tie stall0", 32'(m0_stall), 0);
        chk("rw tie stall1", 32'(m1_stall), 1);
        chk("rw tie ack0", 32'(m0_ack), 0);
        next_cycle(); m0_stb = 1'b0; m1_stb = 1'b0; #1;
        chk("rw reissue addr", wb_addr, 32'h10);
        next_cycle(); #1;
        next_cycle(); wb_rdata = 32'h42; #1;
        chk("rw ack0", 32'(m0_ack), 1);
        chk("rw data0", m0_rdata, 32'h42);

        // Fixed priority under constant contention: port 0 wins every arbitration
        for (int k = 0; k < 12; k++) begin
            next_cycle(); f_stb0 = 1'b1; f_stb1 = 1'b1; #1;
            chk($sformatf("fp%0d stall1", k), 32'(f_stall1), 1);
            chk($sformatf("fp%0d ack1", k), 32'(f_ack1), 0);
            chk($sformatf("fp%0d data1", k), f_rdata1, 0);
            chk($sformatf("fp%0d err", k), 32'({f_err0, f_err1}), 0);
            chk($sformatf("fp%0d stall0", k), 32'(f_stall0), (k % 4 == 0) ? 0 : 1);
            chk($sformatf("fp%0d ack0", k), 32'(f_ack0), (k % 4 == 3) ? 1 : 0);
            chk($sformatf("fp%0d data0", k), f_rdata0, (k % 4 == 3) ? 32'h600D_0000 : 0);
            if (k % 4 == 1) begin
                chk($sformatf("fp%0d wb_stb", k), 32'(f_wb_stb), 1);
                chk($sformatf("fp%0d wb_addr", k), f_wb_addr, 32'h10);
                chk($sformatf("fp%0d wb_wr", k), {f_wb_wdata[30:0], f_wb_we}, 0);
                chk($sformatf("fp%0d wb_sel", k), 32'(f_wb_sel), 32'(3'b010));
            end
        end
        f_stb0 = 1'b0; f_stb1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
